tile_center_painter: RTL and testbench

//  Write-side counterpart of the tile-centre hit test on the 640-wide, 19-bit framebuffer.

---
 rtl/lightbike_pkg.sv | 34 +++
 rtl/tile_center_painter_if.sv | 42 ++++
 rtl/tile_sweep_counter.sv | 62 ++++++
 rtl/tile_center_painter.sv | 99 +++++++++
 tb/tb_tile_center_painter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lightbike_pkg.sv
// Shared lightbike constants: framebuffer geometry, tile-centre bounds, painter FSM encoding.
// The centre hit test lives here so painter and hit-test blocks agree on the region.
package lightbike_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned TILE_SIZE = 30;
  localparam int unsigned ROW_LO    = 7;
  localparam int unsigned ROW_HI    = 22;
  localparam int unsigned COL_LO    = 8;
  localparam int unsigned COL_HI    = 22;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPaint = 2'd1,
    StDone  = 2'd2
  } paint_state_e;

  // True when addr lies in the centre region of the tile whose top-left is base.
  function automatic logic center_hit(input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    int unsigned       row;
    int unsigned       col;
    off = addr - base;
    row = 32'(off) / SCREEN_W;
    col = 32'(off) % SCREEN_W;
    return (row < TILE_SIZE) && (col < TILE_SIZE) &&
           (row >= ROW_LO) && (row <= ROW_HI) && (col >= COL_LO) && (col <= COL_HI);
  endfunction

endpackage

// File: rtl/tile_center_painter_if.sv
// Request and framebuffer write-port bundle for the tile centre painter.
interface tile_center_painter_if
  import lightbike_pkg::*;
();

  logic              start;
  logic [ADDR_W-1:0] startaddr;
  logic [DATA_W-1:0] color;
  logic              wr_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  // Game logic / framebuffer side.
  modport master (
    output start,
    output startaddr,
    output color,
    output wr_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  busy,
    input  done
  );

  // Painter side.
  modport slave (
    input  start,
    input  startaddr,
    input  color,
    input  wr_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output busy,
    output done
  );

endinterface

// File: rtl/tile_sweep_counter.sv
// Row/column sweep over the tile centre with an incremental row-base accumulator.
// addr_next_o is the address that becomes current after this cycle's load/advance.
module tile_sweep_counter
  import lightbike_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_next_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] RowLoOffset = ADDR_W'(ROW_LO * SCREEN_W);
  localparam logic [ADDR_W-1:0] Stride      = ADDR_W'(SCREEN_W);
  localparam logic [CNT_W-1:0]  RowLo       = CNT_W'(ROW_LO);
  localparam logic [CNT_W-1:0]  RowHi       = CNT_W'(ROW_HI);
  localparam logic [CNT_W-1:0]  ColLo       = CNT_W'(COL_LO);
  localparam logic [CNT_W-1:0]  ColHi       = CNT_W'(COL_HI);

  logic [CNT_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  assign last_o = (row_q == RowHi) && (col_q == ColHi);

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    if (load_i) begin
      row_d      = RowLo;
      col_d      = ColLo;
      row_base_d = base_i + RowLoOffset;
    end else if (advance_i) begin
      if (col_q == ColHi) begin
        col_d      = ColLo;
        row_d      = row_q + 1'b1;
        row_base_d = row_base_q + Stride;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Sums deliberately wrap at ADDR_W bits.
  assign addr_next_o = row_base_d + ADDR_W'(col_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/tile_center_painter.sv
// Paints the centre of a 30x30 tile with one framebuffer write per accepted cycle.
// Optional TILE_PAINT_ABORT_EN adds an abort input that ends a sweep early.
module tile_center_painter
  import lightbike_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
`ifdef TILE_PAINT_ABORT_EN
  input  logic                 abort,
`endif
  tile_center_painter_if.slave bus
);

  paint_state_e      state_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;

  logic              abort_w;
  logic              fire;
  logic              load;
  logic              last;
  logic [ADDR_W-1:0] addr_next;

`ifdef TILE_PAINT_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign fire = wr_en_q && bus.wr_ready;
  assign load = (state_q == StIdle) && bus.start;

  tile_sweep_counter u_sweep (
    .clk_i       (clock),
    .rst_ni      (resetn),
    .load_i      (load),
    .advance_i   (fire),
    .base_i      (bus.startaddr),
    .addr_next_o (addr_next),
    .last_o      (last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q   <= StPaint;
            wr_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            wr_addr_q <= addr_next;
            wr_data_q <= bus.color;
          end
        end
        StPaint: begin
          if (fire) begin
            wr_addr_q <= addr_next;
          end
          // A transfer in the abort cycle still completes before the sweep ends.
          if ((fire && last) || abort_w) begin
            state_q <= StDone;
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_tile_center_painter.sv
// Scoreboard bench for tile_center_painter; define TILE_PAINT_ABORT_EN to cover abort.
module tb_tile_center_painter;

  logic clock;
  logic resetn;
  logic abort;

  tile_center_painter_if bus ();

  tile_center_painter dut (
    .clock  (clock),
    .resetn (resetn),
`ifdef TILE_PAINT_ABORT_EN
    .abort  (abort),
`endif
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;
  int cyc;
  int xfer_cnt;
  int done_cnt;
  int hold_cnt;
  int done_cyc;
  int last_xfer_cyc;
  logic [18:0] first_addr;
  logic [18:0] addr16;
  logic [18:0] last_addr;
  logic [18:0] cur_base;
  logic [7:0]  exp_color;
  logic [18:0] exp_q[$];

  // Independent centre-region test: offset from base decomposed into row/col.
  function automatic bit in_center(input logic [18:0] base, input logic [18:0] addr);
    logic [18:0] off;
    int r;
    int c;
    off = addr - base;
    r = int'(off) / 640;
    c = int'(off) % 640;
    return (r >= 7) && (r <= 22) && (c >= 8) && (c <= 22);
  endfunction

  always @(negedge clock) begin
    logic [18:0] e;
    cyc++;
    if (resetn) begin
      if (bus.wr_en && bus.wr_addr == 19'd5128) hold_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL done_cycle: wr_en=%b busy=%b expected wr_en=0 busy=1",
                   bus.wr_en, bus.busy);
        end
      end
      if (bus.wr_en && bus.wr_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        if (xfer_cnt == 1) first_addr = bus.wr_addr;
        if (xfer_cnt == 16) addr16 = bus.wr_addr;
        last_addr = bus.wr_addr;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_addr: got %0d expected no write", bus.wr_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.wr_addr !== e) begin
            errors++;
            $display("FAIL write_addr #%0d: got %0d expected %0d", xfer_cnt, bus.wr_addr, e);
          end
        end
        checks++;
        if (bus.wr_data !== exp_color) begin
          errors++;
          $display("FAIL write_data: got %h expected %h", bus.wr_data, exp_color);
        end
        checks++;
        if (!in_center(cur_base, bus.wr_addr)) begin
          errors++;
          $display("FAIL hit_test: addr %0d outside centre of base %0d", bus.wr_addr, cur_base);
        end
      end
    end
  end

  task automatic start_sweep(input logic [18:0] base, input logic [7:0] colr);
    exp_color = colr;
    cur_base  = base;
    xfer_cnt  = 0;
    done_cnt  = 0;
    hold_cnt  = 0;
    done_cyc  = -1;
    last_xfer_cyc = -1;
    for (int r = 7; r <= 22; r++)
      for (int c = 8; c <= 22; c++)
        exp_q.push_back(19'(int'(base) + r * 640 + c));
    @(posedge clock); #1;
    bus.startaddr = base;
    bus.color     = colr;
    bus.start     = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // Returns in the DONE cycle (just after the edge that raised done).
  task automatic wait_done(input int stall_len, input bit repulse);
    int stalls;
    bit pulsed;
    bit found;
    stalls = 0;
    pulsed = 0;
    found  = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        if (repulse) bus.start = 1'b1;
        bus.wr_ready = 1'b1;
        found = 1;
        break;
      end
      if (repulse && !pulsed && xfer_cnt == 100) begin
        bus.start = 1'b1;
        pulsed = 1;
      end
      if (xfer_cnt == 15 && stalls < stall_len) begin
        bus.wr_ready = 1'b0;
        stalls++;
      end else begin
        bus.wr_ready = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL done_timeout: no done within 3000 cycles, transfers=%0d", xfer_cnt);
    end
  endtask

  task automatic check_sweep(input string name, input int exp_n, input logic [18:0] exp_first,
                             input logic [18:0] exp_last);
    checks++;
    if (xfer_cnt !== exp_n) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, xfer_cnt, exp_n);
    end
    checks++;
    if (first_addr !== exp_first) begin
      errors++;
      $display("FAIL %s first: got %0d expected %0d", name, first_addr, exp_first);
    end
    checks++;
    if (last_addr !== exp_last) begin
      errors++;
      $display("FAIL %s last: got %0d expected %0d", name, last_addr, exp_last);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_xfer_cyc + 1) begin
      errors++;
      $display("FAIL %s done: pulses=%0d at %0d expected 1 at %0d", name, done_cnt, done_cyc,
               last_xfer_cyc + 1);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s leftover: got %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.wr_addr !== 19'd0 || bus.wr_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: en=%b busy=%b done=%b addr=%0d data=%0d expected all 0",
               bus.wr_en, bus.busy, bus.done, bus.wr_addr, bus.wr_data);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    start_sweep(19'd0, 8'hA5);
    wait_done(0, 0);
    @(posedge clock); #1;
    check_sweep("basic", 240, 19'd4488, 19'd14102);
    checks++;
    if (addr16 !== 19'd5128) begin
      errors++;
      $display("FAIL basic addr16: got %0d expected 5128", addr16);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL basic idle: busy=%b wr_en=%b expected 0 0", bus.busy, bus.wr_en);
    end
  endtask

  task automatic test_offset();
    start_sweep(19'd1000, 8'h3C);
    wait_done(0, 0);
    @(posedge clock); #1;
    check_sweep("offset", 240, 19'd5488, 19'd15102);
  endtask

  task automatic test_stall();
    start_sweep(19'd0, 8'h5A);
    wait_done(3, 0);
    @(posedge clock); #1;
    check_sweep("stall", 240, 19'd4488, 19'd14102);
    checks++;
    if (hold_cnt !== 4) begin
      errors++;
      $display("FAIL stall hold: got %0d cycles expected 4", hold_cnt);
    end
  endtask

  task automatic test_wrap();
    start_sweep(19'h7FFFF, 8'h11);
    wait_done(0, 0);
    @(posedge clock); #1;
    check_sweep("wrap", 240, 19'd4487, 19'd14101);
  endtask

  task automatic test_back_to_back();
    start_sweep(19'd2000, 8'h77);
    wait_done(0, 1);
    @(posedge clock); #1;
    // Now in IDLE with start still held high from the DONE cycle.
    check_sweep("restart_first", 240, 19'd6488, 19'd16102);
    exp_color = 8'h77;
    xfer_cnt  = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    last_xfer_cyc = -1;
    for (int r = 7; r <= 22; r++)
      for (int c = 8; c <= 22; c++)
        exp_q.push_back(19'(2000 + r * 640 + c));
    @(posedge clock); #1;
    bus.start = 1'b0;
    wait_done(0, 0);
    @(posedge clock); #1;
    check_sweep("restart_second", 240, 19'd6488, 19'd16102);
  endtask

  task automatic test_reset_mid();
    bit reached;
    reached = 0;
    start_sweep(19'd0, 8'h22);
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1;
      if (xfer_cnt == 100) begin
        reached = 1;
        break;
      end
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (!reached || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async: reached=%0d wr_en=%b busy=%b expected 1 0 0",
               reached, bus.wr_en, bus.busy);
    end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (xfer_cnt !== 100 || done_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid counts: xfers=%0d done=%0d expected 100 0", xfer_cnt, done_cnt);
    end
    resetn = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
  endtask

`ifdef TILE_PAINT_ABORT_EN
  task automatic test_abort();
    start_sweep(19'd0, 8'h99);
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1;
      if (xfer_cnt == 49) break;
    end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (xfer_cnt !== 50 || done_cnt !== 1 || done_cyc !== last_xfer_cyc + 1) begin
      errors++;
      $display("FAIL abort: xfers=%0d done=%0d at %0d expected 50 1 at %0d",
               xfer_cnt, done_cnt, done_cyc, last_xfer_cyc + 1);
    end
    exp_q.delete();
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    xfer_cnt      = 0;
    done_cnt      = 0;
    hold_cnt      = 0;
    abort         = 1'b0;
    bus.start     = 1'b0;
    bus.startaddr = '0;
    bus.color     = '0;
    bus.wr_ready  = 1'b1;
    cur_base      = '0;
    exp_color     = '0;
    test_reset();
    test_basic();
    test_offset();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef TILE_PAINT_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
